// File: rtl/gene_net_pkg.sv
// Shared types and constants for the gene-network fixed-point sweep.
package gene_net_pkg;

  localparam int unsigned GENE_W            = 8;
  localparam int unsigned MAX_STEPS_DEFAULT = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  // Next initial value in a sweep; wraps 255 -> 0.
  function automatic logic [GENE_W-1:0] wrap_inc(input logic [GENE_W-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/gene_result_reg.sv
// Holding register for one sweep result, presented over valid/ready.
module gene_result_reg
  import gene_net_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_fixed,
  input  logic [GENE_W-1:0] i_init,
  input  logic [GENE_W-1:0] i_state,
  input  logic [STEP_W-1:0] i_steps,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_fixed,
  output logic [GENE_W-1:0] o_init,
  output logic [GENE_W-1:0] o_state,
  output logic [STEP_W-1:0] o_steps
);

  logic              r_valid;
  logic              r_fixed;
  logic [GENE_W-1:0] r_init;
  logic [GENE_W-1:0] r_state;
  logic [STEP_W-1:0] r_steps;

  // Capture on load, drop valid on accept or clear; data only changes on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_fixed <= 1'b0;
      r_init  <= '0;
      r_state <= '0;
      r_steps <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_fixed <= i_fixed;
      r_init  <= i_init;
      r_state <= i_state;
      r_steps <= i_steps;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_fixed = r_fixed;
  assign o_init  = r_init;
  assign o_state = r_state;
  assign o_steps = r_steps;

endmodule

// File: rtl/gene_sweep_driver.sv
// Sweeps a range of initial gene states, iterates the external network until
// the checker reports a fixed point or the step budget runs out, and reports
// one result per initial value.
module gene_sweep_driver
  import gene_net_pkg::*;
#(
  parameter int unsigned MAX_STEPS = MAX_STEPS_DEFAULT,
  parameter int unsigned STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GENE_W-1:0] first_init,
  input  logic [GENE_W-1:0] last_init,
  input  logic [GENE_W-1:0] next_x,
  input  logic              fp_flag,
  output logic [GENE_W-1:0] x,
  output logic [GENE_W-1:0] init_val_chk,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [GENE_W-1:0] res_init,
  output logic [GENE_W-1:0] res_state,
  output logic [STEP_W-1:0] res_steps,
  output logic              res_fixed
);

  state_t            r_state, w_state_nxt;
  logic [GENE_W-1:0] r_init_cur, w_init_cur_nxt;
  logic [GENE_W-1:0] r_last_q, w_last_q_nxt;
  logic [GENE_W-1:0] r_x, w_x_nxt;
  logic [GENE_W-1:0] r_ivc, w_ivc_nxt;
  logic [STEP_W-1:0] r_steps, w_steps_nxt;
  logic              r_busy;
  logic              r_done, w_done_nxt;

  logic              w_qual;
  logic              w_timeout;
  logic              w_accept;
  logic              w_res_load;
  logic              w_res_fixed;

  // The first two RUN cycles see checker history from before this load.
  assign w_qual    = fp_flag && (r_steps >= STEP_W'(2));
  assign w_timeout = (r_steps == STEP_W'(MAX_STEPS));
  assign w_accept  = res_valid && res_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath next values; abort overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cur_nxt = r_init_cur;
    w_last_q_nxt   = r_last_q;
    w_x_nxt        = r_x;
    w_ivc_nxt      = r_ivc;
    w_steps_nxt    = r_steps;
    w_done_nxt     = 1'b0;
    w_res_load     = 1'b0;
    w_res_fixed    = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_init_cur_nxt = first_init;
            w_last_q_nxt   = last_init;
            w_state_nxt    = S_LOAD;
          end
        end
        S_LOAD: begin
          w_x_nxt     = r_init_cur;
          w_ivc_nxt   = r_init_cur;
          w_steps_nxt = '0;
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_qual) begin
            w_res_load  = 1'b1;
            w_res_fixed = 1'b1;
            w_state_nxt = S_REPORT;
          end else if (w_timeout) begin
            w_res_load  = 1'b1;
            w_state_nxt = S_REPORT;
          end else begin
            w_x_nxt     = next_x;
            w_steps_nxt = r_steps + 1'b1;
          end
        end
        S_REPORT: begin
          if (w_accept) begin
            if (r_init_cur == r_last_q) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_init_cur_nxt = wrap_inc(r_init_cur);
              w_state_nxt    = S_LOAD;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath registers; busy is registered from the next state so it tracks the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cur <= '0;
      r_last_q   <= '0;
      r_x        <= '0;
      r_ivc      <= '0;
      r_steps    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_init_cur <= w_init_cur_nxt;
      r_last_q   <= w_last_q_nxt;
      r_x        <= w_x_nxt;
      r_ivc      <= w_ivc_nxt;
      r_steps    <= w_steps_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  gene_result_reg #(
    .STEP_W (STEP_W)
  ) u_result (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (abort),
    .i_load  (w_res_load),
    .i_fixed (w_res_fixed),
    .i_init  (r_init_cur),
    .i_state (r_x),
    .i_steps (r_steps),
    .i_ready (res_ready),
    .o_valid (res_valid),
    .o_fixed (res_fixed),
    .o_init  (res_init),
    .o_state (res_state),
    .o_steps (res_steps)
  );

  assign x            = r_x;
  assign init_val_chk = r_ivc;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_gene_sweep_driver.sv
// Bench for gene_sweep_driver: external network and fixed-point checker are
// modelled here; expected results come from iterating the network directly.
module tb_gene_sweep_driver;

  localparam int unsigned MAXS = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] first_init = '0;
  logic [7:0] last_init = '0;
  logic [7:0] next_x;
  logic       fp_flag;
  logic [7:0] x, init_val_chk, res_init, res_state, res_steps;
  logic       busy, done, res_valid, res_fixed;

  logic [7:0] chk_prev;
  logic [1:0] net_mode = 2'd0;
  logic [7:0] lut [256];

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;

  logic [7:0] last_state, last_steps;
  logic       last_fixed;

  always #5 clk = ~clk;

  gene_sweep_driver #(
    .MAX_STEPS (MAXS),
    .STEP_W    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .first_init   (first_init),
    .last_init    (last_init),
    .next_x       (next_x),
    .fp_flag      (fp_flag),
    .x            (x),
    .init_val_chk (init_val_chk),
    .busy         (busy),
    .done         (done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_init     (res_init),
    .res_state    (res_state),
    .res_steps    (res_steps),
    .res_fixed    (res_fixed)
  );

  // Network: 0 identity, 1 oscillator, 2 increment-to-saturate, 3 random table.
  assign next_x = (net_mode == 2'd0) ? x :
                  (net_mode == 2'd1) ? ~x :
                  (net_mode == 2'd2) ? ((x == 8'hFF) ? x : x + 8'd1) :
                  lut[x];

  // Fixed-point checker: registered compare of the previous and current x.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_prev <= '0;
      fp_flag  <= 1'b0;
    end else begin
      chk_prev <= x;
      fp_flag  <= (x == chk_prev);
    end
  end

  function automatic logic [7:0] netf(input logic [7:0] v);
    case (net_mode)
      2'd0:    return v;
      2'd1:    return ~v;
      2'd2:    return (v == 8'hFF) ? v : v + 8'd1;
      default: return lut[v];
    endcase
  endfunction

  // Trajectory x0=v, xs=f(x(s-1)). The checker flags xs-1==xs-2 while at step s;
  // the first such s>=2 within budget is a fixed point, else timeout at MAXS.
  function automatic void model(input logic [7:0] v, output logic [7:0] st,
                                output logic [7:0] n, output logic fx);
    logic [7:0] seq [MAXS+1];
    seq[0] = v;
    for (int s = 1; s <= MAXS; s++) seq[s] = netf(seq[s-1]);
    fx = 1'b0;
    n  = 8'(MAXS);
    st = seq[MAXS];
    for (int s = 2; s <= MAXS; s++) begin
      if (seq[s-1] == seq[s-2]) begin
        fx = 1'b1;
        n  = 8'(s);
        st = seq[s];
        break;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l,
                           input int unsigned stall, input bit rnd_stall);
    logic [7:0]  span, v, es, en;
    logic        ef;
    int unsigned n_res, cyc, st;
    logic [31:0] snap;
    span  = l - f;
    n_res = 32'(span) + 1;
    first_init = f;
    last_init  = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int unsigned k = 0; k < n_res; k++) begin
      v = f + 8'(k);
      model(v, es, en, ef);
      cyc = 0;
      while (!res_valid && cyc < MAXS + 16) begin
        @(negedge clk);
        cyc++;
      end
      chk("res_valid_wait", 32'(res_valid), 32'd1);
      chk("res_init", 32'(res_init), 32'(v));
      chk("res_state", 32'(res_state), 32'(es));
      chk("res_steps", 32'(res_steps), 32'(en));
      chk("res_fixed", 32'(res_fixed), 32'(ef));
      chk("init_val_chk", 32'(init_val_chk), 32'(v));
      last_state = res_state;
      last_steps = res_steps;
      last_fixed = res_fixed;
      snap = {6'b0, res_valid, res_init, res_state, res_steps, res_fixed};
      st = rnd_stall ? $urandom_range(0, stall) : stall;
      for (int unsigned s = 0; s < st; s++) begin
        @(negedge clk);
        chk("stall_hold", {6'b0, res_valid, res_init, res_state, res_steps, res_fixed}, snap);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("valid_drop", 32'(res_valid), 32'd0);
      chk("done_pulse", 32'(done), 32'(k == n_res - 1));
      chk("busy_after_accept", 32'(busy), 32'(k != n_res - 1));
    end
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  xa, f, l;
    int unsigned cyc;

    for (int i = 0; i < 256; i++) lut[i] = 8'(i);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_ivc", 32'(init_val_chk), 32'd0);
    chk("rst_res", {res_valid, res_fixed, res_init, res_state, res_steps}, 32'd0);
    chk("rst_busy_done", {busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Same init 0x00 twice with checker history already at 0x00
    net_mode = 2'd0;
    run_sweep(8'h00, 8'h00, 0, 1'b0);
    chk("b2b0_steps_a", 32'(last_steps), 32'd2);
    run_sweep(8'h00, 8'h00, 1, 1'b0);
    chk("b2b0_steps_b", 32'(last_steps), 32'd2);

    // Identity single value
    run_sweep(8'h5A, 8'h5A, 0, 1'b0);
    chk("id_state", 32'(last_state), 32'h5A);
    chk("id_steps", 32'(last_steps), 32'd2);
    chk("id_fixed", 32'(last_fixed), 32'd1);
    run_sweep(8'h5A, 8'h5A, 0, 1'b0);
    chk("id_repeat_steps", 32'(last_steps), 32'd2);

    // Oscillator: timeout
    net_mode = 2'd1;
    run_sweep(8'h0F, 8'h0F, 0, 1'b0);
    chk("osc_state", 32'(last_state), 32'h0F);
    chk("osc_steps", 32'(last_steps), 32'd64);
    chk("osc_fixed", 32'(last_fixed), 32'd0);

    // Increment to saturation
    net_mode = 2'd2;
    run_sweep(8'hFC, 8'hFC, 0, 1'b0);
    chk("sat_state", 32'(last_state), 32'hFF);
    chk("sat_steps", 32'(last_steps), 32'd5);
    chk("sat_fixed", 32'(last_fixed), 32'd1);

    // Wrap sweep with stalled consumer, then full range
    net_mode = 2'd0;
    run_sweep(8'd254, 8'd1, 3, 1'b0);
    run_sweep(8'd250, 8'd3, 1, 1'b1);
    run_sweep(8'd0, 8'd255, 0, 1'b0);

    // Random network tables and ranges
    net_mode = 2'd3;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++)
        lut[i] = ($urandom_range(0, 3) == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      f = 8'($urandom);
      l = f + 8'($urandom_range(0, 3));
      run_sweep(f, l, 3, 1'b1);
    end

    // Abort during RUN, coinciding with start
    net_mode = 2'd1;
    first_init = 8'h40;
    last_init  = 8'h40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    xa = x;
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_x_hold", 32'(x), 32'(xa));
    chk("abort_ivc_hold", 32'(init_val_chk), 32'h40);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", {busy, done, res_valid}, 32'd0);
    chk("abort_x_hold_later", 32'(x), 32'(xa));

    // Abort beats the handshake in REPORT
    net_mode = 2'd0;
    first_init = 8'h10;
    last_init  = 8'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < MAXS + 16) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_rep_valid_wait", 32'(res_valid), 32'd1);
    abort = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    res_ready = 1'b0;
    chk("abort_rep_out", {busy, done, res_valid}, 32'd0);
    @(negedge clk);
    chk("abort_rep_no_done", 32'(done), 32'd0);

    // Reset asserted while a result is pending
    first_init = 8'h33;
    last_init  = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < MAXS + 16) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_valid_wait", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_x", 32'(x), 32'd0);
    chk("rst_mid_res", {res_init, res_state, res_steps}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_done", {busy, done, res_valid}, 32'd0);
    run_sweep(8'h77, 8'h78, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
